// File: rtl/decod_grant_sched_pkg.sv
// Shared constants, FSM state type and helpers for decod_grant_sched.
package decod_grant_sched_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/decod_grant_sched_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above ptr,
// otherwise lowest set request overall (wrap-around).
module rr_pick
    import decod_grant_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] w_masked;
    logic             w_found_m;
    logic             w_found_u;
    logic [IDX_W-1:0] w_idx_m;
    logic [IDX_W-1:0] w_idx_u;

    assign w_masked = req & ({N_REQ{1'b1}} << ptr);

    always_comb begin
        w_found_m = 1'b0;
        w_found_u = 1'b0;
        w_idx_m   = '0;
        w_idx_u   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_masked[i] && !w_found_m) begin
                w_found_m = 1'b1;
                w_idx_m   = IDX_W'(i);
            end
            if (req[i] && !w_found_u) begin
                w_found_u = 1'b1;
                w_idx_u   = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = w_found_m ? w_idx_m : w_idx_u;

endmodule

// File: rtl/decod_grant_sched.sv
// Round-robin grant scheduler driving a 4-to-16 one-hot decoder with a one-cycle gap.
// Optional hold-timeout: define DECOD_GRANT_SCHED_TIMEOUT_EN.
module decod_grant_sched
    import decod_grant_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 64
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] sel,
    output logic             en,
    output logic [N_REQ-1:0] gnt_oh,
    output logic             busy,
    output logic             timeout
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] w_sel_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_any;
    logic [IDX_W-1:0] w_pick;
    logic             w_expire;
    logic             w_release;

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

`ifdef DECOD_GRANT_SCHED_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Counter sits at zero outside GRANT, so it is already cleared on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (r_state != GRANT)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

    assign w_expire = (r_state == GRANT) && (r_cnt == 16'(MAX_HOLD - 1));
    assign timeout  = w_expire && !done && req[r_sel];
`else
    logic w_unused_hold;
    assign w_unused_hold = (MAX_HOLD > 1);
    assign w_expire      = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign w_release = done || !req[r_sel] || w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE, GAP: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_pick;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = GAP;
                    w_ptr_nxt   = r_sel + IDX_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sel    = r_sel;
    assign en     = (r_state == GRANT);
    assign busy   = (r_state != IDLE);
    assign gnt_oh = en ? idx_to_onehot(r_sel) : '0;

endmodule

// File: doc/decod_grant_sched.md
Name: decod_grant_sched

Overview:
- Round-robin scheduler that shares the 4-to-16 one-hot decoder's output lines between 16 requesters.
- Drives the decoder's 4-bit select and enable.
- Only one decoder output is ever active at a time.
- Enforces a one-cycle dead gap between successive grants so two one-hot lines never overlap across a handover.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 to match the decoder's output count.
- IDX_W, 4, select width; equals log2(N_REQ).
- MAX_HOLD, 64, maximum cycles a grant may last (used only with the timeout feature); legal range 2..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  16  request vector; a requester holds its bit high until it is served.
- done  in  1  release pulse from the current grantee; ignored outside GRANT.
- sel  out  4  decoder select, the index of the current grantee.
- en  out  1  decoder enable; high only in GRANT.
- gnt_oh  out  16  one-hot copy of the grant, for checkers and requesters; all zeros when en=0.
- busy  out  1  high in GRANT and GAP.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE.
  - sel=0, en=0, gnt_oh=0, busy=0, timeout=0.
  - Round-robin pointer ptr=0; index 0 has highest priority.
  - Hold counter = 0.
- States:
  - IDLE: no grant active.
    - If req != 0, the winner is the first set bit at or after ptr, searching upward and wrapping 15->0.
    - Next cycle: state=GRANT, sel=winner, en=1, gnt_oh=1<<winner.
    - Latency from req to en is exactly 1 cycle.
  - GRANT: sel is held stable. Release occurs on any of:
    - done=1;
    - req[sel]=0 (requester withdrew);
    - hold-counter expiry (timeout feature only).
    - On release: state=GAP, en=0, gnt_oh=0, ptr=(sel+1) mod 16, so 15 wraps to 0.
    - done and the req drop in the same cycle count as one release.
  - GAP: exactly one cycle with en=0 and busy=1.
    - Arbitration runs using the updated ptr.
    - If any req is set: GRANT next cycle. Otherwise: IDLE.
    - Back-to-back grants are therefore spaced by exactly one idle cycle on en.
- Req changes outside GRANT only affect the next arbitration; there is no registered request history.
- sel holds its last value while en=0. Downstream must qualify with en.
- A requester that is granted then drops its req in its first GRANT cycle gets a 1-cycle grant, then GAP.
- Reset asserted mid-grant drops en in the same cycle (asynchronous). All state returns to reset values.
- Invariant: popcount(gnt_oh) <= 1 always, and gnt_oh == (en ? 1<<sel : 0).

Optional Feature:
- Macro: DECOD_GRANT_SCHED_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches MAX_HOLD-1 without another release cause, the grant is force-released on that cycle with the normal GAP/ptr update, and timeout pulses high for that cycle.
  - A done arriving in the expiry cycle is a normal release; timeout stays 0.
- Undefined:
  - No counter logic is built and timeout is tied to 0.
  - Grants last until done or the req drops.

Decomposition:
- Package decod_grant_sched_pkg holds:
  - N_REQ=16 and IDX_W=4;
  - state enum {IDLE, GRANT, GAP};
  - the function idx_to_onehot.
- One natural sub-module, rr_pick: purely combinational masked priority encoder.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: any, idx[3:0].
  - Implementation: two-pass search (bits at or above ptr first, then unmasked).

Test Plan:
- Reset, then req=16'h0001 -> next cycle en=1, sel=0, gnt_oh=16'h0001; done pulse -> en=0 next cycle, busy=1 for 1 cycle, then IDLE.
- req=16'hFFFF held with done every 3rd GRANT cycle -> sel sequence 0,1,2,...,15,0, with exactly one en=0 cycle between grants; checks the 15->0 wrap.
- ptr=5 (after serving 4), req=16'h0018 -> winner 3 (wrap search), not 4-first ordering violation; then req=16'h8010 -> winner 4.
- Grant on 7 with req[7] dropped and done asserted in the same cycle -> single release, ptr=8, no duplicate GAP.
- With DECOD_GRANT_SCHED_TIMEOUT_EN and MAX_HOLD=4, req=16'h0004 held, no done -> en high exactly 4 cycles, timeout=1 in the 4th, then GAP, then re-grant to 2.
- Assert rst mid-GRANT (sel=9) -> en=0, gnt_oh=0, sel=0 immediately; after release, req=16'h0200 -> sel=9 with 1-cycle latency.
